// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: a direct-mapped table of 2-bit saturating
// counters, fetch-time prediction, training from EX resolutions, and
// misprediction recovery (MISS pulse, FLUSH window, redirect PC).
module branch_predict_ctrl #(
  parameter int INDEX_BITS   = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC_IF,
  input  logic                 BRANCH_IF,
  output logic                 PREDICTION,
  input  logic                 RESOLVE_VALID,
  input  logic [31:0]          RESOLVE_PC,
  input  logic                 RESOLVE_PRED,
  input  logic                 OUTCOME,
  input  logic [31:0]          TARGET,
  input  logic [31:0]          PC_PLUS4,
  output logic                 MISS,
  output logic                 FLUSH,
  output logic [31:0]          REDIRECT_PC,
  output logic [CNT_WIDTH-1:0] BRANCH_COUNT,
  output logic [CNT_WIDTH-1:0] MISS_COUNT
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  // The down-counter counts the remaining FLUSH cycles after the current one.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MISS  = 2'd1,   // first FLUSH cycle, MISS pulse high
    S_FLUSH = 2'd2    // remaining FLUSH cycles
  } state_t;

  state_t                state, state_nxt;
  logic [2:0]            fcnt;
  logic [1:0]            tbl [ENTRIES];
  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] rs_idx;
  logic                  accept;
  logic                  miss;
  logic [31:0]           redirect_pc;
  logic [CNT_WIDTH-1:0]  branch_cnt;
  logic [CNT_WIDTH-1:0]  miss_cnt;
  logic                  unused_pc_bits;

  // Saturating 2-bit counter update toward the actual direction.
  function automatic logic [1:0] sat_train(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Performance counter increment that sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign if_idx = PC_IF[INDEX_BITS+1:2];
  assign rs_idx = RESOLVE_PC[INDEX_BITS+1:2];

  // Only the index bits of the PCs address the table.
  assign unused_pc_bits = ^{PC_IF[31:INDEX_BITS+2], PC_IF[1:0],
                            RESOLVE_PC[31:INDEX_BITS+2], RESOLVE_PC[1:0]};

  // Resolutions arriving during a flush belong to the squashed path.
  assign accept = RESOLVE_VALID && (state == S_IDLE);
  assign miss   = accept && (OUTCOME != RESOLVE_PRED);

  // Lookup sees the table before any same-cycle training write.
  assign PREDICTION = BRANCH_IF & tbl[if_idx][1];

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: leave the flush window when the down-counter is exhausted.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (miss) state_nxt = S_MISS;
      S_MISS:  state_nxt = (fcnt == 3'd0) ? S_IDLE : S_FLUSH;
      S_FLUSH: if (fcnt == 3'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    MISS  = (state == S_MISS);
    FLUSH = (state != S_IDLE);
  end

  // Flush-window down-counter, loaded on the miss edge.
  always_ff @(posedge CLK) begin
    if (RESET)                             fcnt <= 3'd0;
    else if (miss)                         fcnt <= FLUSH_LOAD;
    else if (state != S_IDLE && fcnt != 0) fcnt <= fcnt - 3'd1;
  end

  // Counter table: reset to weakly not-taken, trained on accepted resolutions.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= 2'b01;
    end else if (accept) begin
      tbl[rs_idx] <= sat_train(tbl[rs_idx], OUTCOME);
    end
  end

  // Redirect address captured on the miss edge and held afterwards.
  always_ff @(posedge CLK) begin
    if (RESET)     redirect_pc <= 32'h0;
    else if (miss) redirect_pc <= OUTCOME ? TARGET : PC_PLUS4;
  end

  // Performance counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (accept) branch_cnt <= sat_inc(branch_cnt);
      if (miss)   miss_cnt   <= sat_inc(miss_cnt);
    end
  end

  assign REDIRECT_PC  = redirect_pc;
  assign BRANCH_COUNT = branch_cnt;
  assign MISS_COUNT   = miss_cnt;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl (INDEX_BITS=4, FLUSH_CYCLES=2).
module tb_branch_predict_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC_IF;
  logic        BRANCH_IF;
  logic        PREDICTION;
  logic        RESOLVE_VALID;
  logic [31:0] RESOLVE_PC;
  logic        RESOLVE_PRED;
  logic        OUTCOME;
  logic [31:0] TARGET;
  logic [31:0] PC_PLUS4;
  logic        MISS;
  logic        FLUSH;
  logic [31:0] REDIRECT_PC;
  logic [15:0] BRANCH_COUNT;
  logic [15:0] MISS_COUNT;

  int checks = 0;
  int errors = 0;

  branch_predict_ctrl #(.INDEX_BITS(4), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .PC_IF(PC_IF), .BRANCH_IF(BRANCH_IF),
    .PREDICTION(PREDICTION), .RESOLVE_VALID(RESOLVE_VALID),
    .RESOLVE_PC(RESOLVE_PC), .RESOLVE_PRED(RESOLVE_PRED), .OUTCOME(OUTCOME),
    .TARGET(TARGET), .PC_PLUS4(PC_PLUS4), .MISS(MISS), .FLUSH(FLUSH),
    .REDIRECT_PC(REDIRECT_PC), .BRANCH_COUNT(BRANCH_COUNT),
    .MISS_COUNT(MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic outc, input logic pred,
                         input logic [31:0] tgt);
    RESOLVE_VALID = 1'b1;
    RESOLVE_PC    = pc;
    OUTCOME       = outc;
    RESOLVE_PRED  = pred;
    TARGET        = tgt;
    PC_PLUS4      = pc + 32'd4;
  endtask

  task automatic idle_res();
    RESOLVE_VALID = 1'b0;
    RESOLVE_PC    = 32'h0;
    OUTCOME       = 1'b0;
    RESOLVE_PRED  = 1'b0;
    TARGET        = 32'h0;
    PC_PLUS4      = 32'h0;
  endtask

  task automatic predict(input string tag, input logic [31:0] pc, input logic exp);
    BRANCH_IF = 1'b1;
    PC_IF     = pc;
    #1;
    chk(tag, {31'b0, PREDICTION}, {31'b0, exp});
  endtask

  initial begin
    RESET = 1'b1; BRANCH_IF = 1'b0; PC_IF = 32'h0;
    idle_res();
    step(); step();
    RESET = 1'b0;
    step();
    chk("rst_miss",   {31'b0, MISS},  32'd0);
    chk("rst_flush",  {31'b0, FLUSH}, 32'd0);
    chk("rst_redir",  REDIRECT_PC,    32'h0);
    chk("rst_bcnt",   {16'b0, BRANCH_COUNT}, 32'd0);
    chk("rst_mcnt",   {16'b0, MISS_COUNT},   32'd0);

    // 1: first miss on PC 0x10, taken
    predict("t1_pred0", 32'h10, 1'b0);
    resolve(32'h10, 1'b1, 1'b0, 32'h100);
    step(); idle_res();
    chk("t1_miss",  {31'b0, MISS},  32'd1);
    chk("t1_flush", {31'b0, FLUSH}, 32'd1);
    chk("t1_redir", REDIRECT_PC,    32'h100);
    chk("t1_mcnt",  {16'b0, MISS_COUNT},   32'd1);
    chk("t1_bcnt",  {16'b0, BRANCH_COUNT}, 32'd1);
    step();
    chk("t1_miss2",  {31'b0, MISS},  32'd0);
    chk("t1_flush2", {31'b0, FLUSH}, 32'd1);
    step();
    chk("t1_flush3", {31'b0, FLUSH}, 32'd0);
    predict("t1_pred1", 32'h10, 1'b1);

    // 2: saturate at 11, then one not-taken miss
    for (int i = 0; i < 3; i++) begin
      resolve(32'h10, 1'b1, 1'b1, 32'h100);
      step();
      chk("t2_nomiss",  {31'b0, MISS},  32'd0);
      chk("t2_noflush", {31'b0, FLUSH}, 32'd0);
    end
    chk("t2_bcnt", {16'b0, BRANCH_COUNT}, 32'd4);
    resolve(32'h10, 1'b0, 1'b1, 32'h100);
    step(); idle_res();
    chk("t2_miss",  {31'b0, MISS}, 32'd1);
    chk("t2_redir", REDIRECT_PC,   32'h14);
    chk("t2_mcnt",  {16'b0, MISS_COUNT}, 32'd2);
    predict("t2_pred_sat", 32'h10, 1'b1);
    step();
    chk("t2_redir_hold", REDIRECT_PC, 32'h14);
    step();
    chk("t2_flush_end", {31'b0, FLUSH}, 32'd0);

    // 3: resolutions during FLUSH are ignored
    resolve(32'h20, 1'b1, 1'b0, 32'h200);
    step();
    chk("t3_flush", {31'b0, FLUSH}, 32'd1);
    resolve(32'h30, 1'b1, 1'b0, 32'h300);
    step();
    chk("t3_flush2", {31'b0, FLUSH}, 32'd1);
    chk("t3_redir",  REDIRECT_PC,    32'h200);
    step(); idle_res();
    chk("t3_flush_end", {31'b0, FLUSH}, 32'd0);
    chk("t3_bcnt", {16'b0, BRANCH_COUNT}, 32'd6);
    chk("t3_mcnt", {16'b0, MISS_COUNT},   32'd3);
    predict("t3_ignored_pc", 32'h30, 1'b0);
    predict("t3_trained_pc", 32'h20, 1'b1);

    // 4: aliasing of 0x04 and 0x44
    for (int i = 0; i < 2; i++) begin
      resolve(32'h04, 1'b1, 1'b1, 32'h0);
      step();
      chk("t4_noflush", {31'b0, FLUSH}, 32'd0);
    end
    idle_res();
    predict("t4_alias", 32'h44, 1'b1);

    // 5: same-cycle lookup and update at index 2
    resolve(32'h08, 1'b1, 1'b1, 32'h0);
    predict("t5_old", 32'h08, 1'b0);
    step(); idle_res();
    predict("t5_new", 32'h08, 1'b1);
    chk("t5_bcnt", {16'b0, BRANCH_COUNT}, 32'd9);

    // 6: reset during first FLUSH cycle
    resolve(32'h0C, 1'b1, 1'b0, 32'h400);
    step(); idle_res();
    chk("t6_flush_pre", {31'b0, FLUSH}, 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("t6_flush", {31'b0, FLUSH}, 32'd0);
    chk("t6_miss",  {31'b0, MISS},  32'd0);
    chk("t6_bcnt",  {16'b0, BRANCH_COUNT}, 32'd0);
    chk("t6_mcnt",  {16'b0, MISS_COUNT},   32'd0);
    for (int i = 0; i < 16; i++) predict("t6_pred_rst", 32'(i * 4), 1'b0);
    resolve(32'h10, 1'b1, 1'b0, 32'h300);
    step(); idle_res();
    chk("t6_miss_new",  {31'b0, MISS},  32'd1);
    chk("t6_flush_new", {31'b0, FLUSH}, 32'd1);
    chk("t6_redir_new", REDIRECT_PC,    32'h300);
    step();
    chk("t6_flush_new2", {31'b0, FLUSH}, 32'd1);
    step();
    chk("t6_flush_new3", {31'b0, FLUSH}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Branch prediction controller for the RV32IM pipeline. Holds a direct-mapped table of 2-bit saturating counters and supplies a taken/not-taken prediction to IF. Checks resolved branches from EX against the prediction carried down the pipe and trains the table. On a mismatch it sequences recovery: one MISS pulse, a multi-cycle FLUSH window and a redirect PC.

Parameters:
INDEX_BITS, 4, table index width; table holds 2**INDEX_BITS counters, indexed by PC[INDEX_BITS+1:2]
FLUSH_CYCLES, 2, number of cycles FLUSH stays high after a misprediction (legal range 1..7)
CNT_WIDTH, 16, width of the performance counters

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous reset, active-high
PC_IF  in  32  PC of the instruction in fetch
BRANCH_IF  in  1  fetched instruction is a conditional branch
PREDICTION  out  1  predicted taken for the fetched branch (combinational)
RESOLVE_VALID  in  1  branch resolved in EX this cycle
RESOLVE_PC  in  32  PC of the resolving branch
RESOLVE_PRED  in  1  prediction originally issued for that branch
OUTCOME  in  1  actual direction, 1 = taken
TARGET  in  32  computed branch target
PC_PLUS4  in  32  fall-through address of the resolving branch
MISS  out  1  one-cycle misprediction pulse (registered)
FLUSH  out  1  squash IF/ID/EX contents, held FLUSH_CYCLES cycles
REDIRECT_PC  out  32  corrected fetch address, valid while FLUSH=1
BRANCH_COUNT  out  CNT_WIDTH  number of accepted resolutions
MISS_COUNT  out  CNT_WIDTH  number of mispredictions

Behaviour:
- One clock, CLK. RESET is synchronous and active-high and is sampled only on the rising edge of CLK.
- Reset values:
  - every table counter = 2'b01 (weakly not-taken)
  - MISS = 0, FLUSH = 0, REDIRECT_PC = 32'h0
  - BRANCH_COUNT = 0, MISS_COUNT = 0
  - FSM = IDLE
- Prediction:
  - PREDICTION = BRANCH_IF & counter[PC_IF index][1].
  - Purely combinational from the current table state; it does not see an update being written in the same cycle. With a same-index lookup and update in one cycle, the old value is returned.
- Acceptance:
  - A resolution is accepted when RESOLVE_VALID = 1 and the FSM is in IDLE.
  - While the FSM is in FLUSH, RESOLVE_VALID is ignored: no training and no count changes, because those instructions are on the squashed path.
- Training on an accepted resolution, at the clock edge:
  - index = RESOLVE_PC[INDEX_BITS+1:2]
  - OUTCOME = 1: counter increments, saturating at 2'b11
  - OUTCOME = 0: counter decrements, saturating at 2'b00
- Miss detection:
  - miss = accepted & (OUTCOME != RESOLVE_PRED).
  - The comparison uses RESOLVE_PRED, not the current table value.
- FSM:
  - IDLE -> FLUSH on an accepted miss.
  - On that edge: MISS <= 1; FLUSH <= 1; REDIRECT_PC <= OUTCOME ? TARGET : PC_PLUS4; an internal down-counter loads FLUSH_CYCLES-1.
  - Latency from the miss cycle to MISS/FLUSH high is exactly 1 cycle.
  - FLUSH: MISS drops to 0 after one cycle. FLUSH and REDIRECT_PC hold until the down-counter reaches 0, then FLUSH <= 0 and the FSM returns to IDLE.
  - FLUSH is high for exactly FLUSH_CYCLES consecutive cycles.
  - An accepted miss in the same cycle the FSM returns to IDLE is impossible: acceptance requires IDLE at sampling time. A miss in the first IDLE cycle after FLUSH starts a new sequence on the next edge.
- REDIRECT_PC keeps its last value after FLUSH falls; it is meaningful only while FLUSH = 1.
- Counters:
  - BRANCH_COUNT increments on every accepted resolution.
  - MISS_COUNT increments on every accepted miss.
  - Both saturate at all-ones and do not wrap.
- A correct prediction causes no MISS, no FLUSH and no redirect; only training and BRANCH_COUNT change.
- RESET asserted mid-FLUSH: on the next edge FLUSH = 0, MISS = 0, FSM = IDLE, and the table and counters return to their reset values.

Test Plan:
1. Reset, then BRANCH_IF=1 with PC_IF=0x00000010 -> PREDICTION=0 (counter 01). Resolve PC 0x10 with OUTCOME=1, RESOLVE_PRED=0:
   - next cycle MISS=1 for 1 cycle
   - FLUSH=1 for 2 cycles
   - REDIRECT_PC=TARGET (0x00000100)
   - MISS_COUNT=1, BRANCH_COUNT=1
   - afterwards PREDICTION for PC 0x10 = 1
2. Three further taken resolutions of PC 0x10 with RESOLVE_PRED=1:
   - no MISS/FLUSH; counter saturates at 11
   - one OUTCOME=0 with RESOLVE_PRED=1 -> MISS, REDIRECT_PC=PC_PLUS4 (0x14); counter 10 and PREDICTION still 1
3. Miss on PC 0x20, then RESOLVE_VALID=1 with a differing outcome on both FLUSH cycles:
   - inputs ignored; counts increase by exactly 1 miss and 1 branch
   - table entry for the ignored PC unchanged
4. Aliasing: PC 0x04 and PC 0x44 (INDEX_BITS=4) share index 1. Training 0x04 taken twice -> PREDICTION for PC_IF=0x44 = 1.
5. Same-cycle lookup and update at index 2, counter 01, OUTCOME=1 -> PREDICTION=0 that cycle and 1 the next cycle.
6. Assert RESET during the first FLUSH cycle -> next edge:
   - FLUSH=0, MISS=0, counts=0
   - all PREDICTIONs=0
   - a new miss afterwards produces the full 2-cycle FLUSH
